// File: rtl/fb_arbiter.sv
// fb_arbiter -- double-buffered framebuffer arbiter.
//
// Shares one single-port pixel memory (two banks, 1-cycle read latency)
// between scanout reads from the front bank and drawing writes to the back
// bank. Scanout reads always win the port. Bank swaps are requested by the
// drawing side and take effect on the next vertical blanking pulse, after
// which the new back bank is optionally filled with CLEAR_COLOR.
//
// Ports
//   pixel_clk, pixel_clk_rstn        clock, async active-low reset
//   rd_req, rd_addr                  scanout read request (front bank)
//   rd_data, rd_valid                scanout return, 2 cycles after rd_req
//   wr_valid, wr_addr, wr_data       drawing write request (back bank)
//   wr_ready                         write accepted when high with wr_valid
//   swap_req, vblank_start           swap request / vblank pulses
//   front_sel, swap_pending, clearing  status
//   drop_count                       saturating count of out-of-range writes
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata             pixel memory port, mem_addr = {bank, addr}
module fb_arbiter #(
    parameter int unsigned       FB_DEPTH      = 76800,
    parameter int unsigned       ADDR_W        = 17,
    parameter int unsigned       DATA_W        = 12,
    parameter bit                CLEAR_ON_SWAP = 1'b1,
    parameter logic [DATA_W-1:0] CLEAR_COLOR   = '0
) (
    input  logic              pixel_clk,
    input  logic              pixel_clk_rstn,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              swap_req,
    input  logic              vblank_start,
    output logic              front_sel,
    output logic              swap_pending,
    output logic              clearing,
    output logic [15:0]       drop_count,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        DRAW,
        WAIT_SWAP,
        CLEAR
    } state_t;

    localparam state_t AFTER_SWAP = CLEAR_ON_SWAP ? CLEAR : DRAW;

    state_t              state_q, state_d;
    logic                front_sel_q, front_sel_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [15:0]         drop_count_q, drop_count_d;
    logic                rd_pend_q;
    logic                rd_valid_q;
    logic [DATA_W-1:0]   rd_data_q;

    logic                wr_acc;
    logic                wr_in_range;
    logic                clr_last;

    always_comb begin
        wr_in_range = (32'(wr_addr) < FB_DEPTH);
        clr_last    = (32'(clr_cnt_q) == (FB_DEPTH - 1));

        // Gated by reset so the port and handshake are quiet while in reset.
        wr_ready = pixel_clk_rstn && (state_q == DRAW) && !rd_req;
        wr_acc   = wr_valid && wr_ready;

        // Memory port mux: scanout read > drawing write > clear fill.
        // Writes and clears only ever address the bank opposite front_sel.
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {~front_sel_q, wr_addr};
        mem_wdata = wr_data;
        if (pixel_clk_rstn) begin
            if (rd_req) begin
                mem_en   = 1'b1;
                mem_addr = {front_sel_q, rd_addr};
            end else if (wr_acc) begin
                // Out-of-range writes complete the handshake but never reach memory.
                mem_en = wr_in_range;
                mem_we = wr_in_range;
            end else if (state_q == CLEAR) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {~front_sel_q, clr_cnt_q};
                mem_wdata = CLEAR_COLOR;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        front_sel_d  = front_sel_q;
        clr_cnt_d    = clr_cnt_q;
        drop_count_d = drop_count_q;

        unique case (state_q)
            DRAW: begin
                if (swap_req) begin
                    // A coincident vblank completes the swap immediately.
                    if (vblank_start) begin
                        front_sel_d = ~front_sel_q;
                        clr_cnt_d   = '0;
                        state_d     = AFTER_SWAP;
                    end else begin
                        state_d = WAIT_SWAP;
                    end
                end
            end
            WAIT_SWAP: begin
                if (vblank_start) begin
                    front_sel_d = ~front_sel_q;
                    clr_cnt_d   = '0;
                    state_d     = AFTER_SWAP;
                end
            end
            CLEAR: begin
                // A scanout read owns the port this cycle; hold the address.
                if (!rd_req) begin
                    if (clr_last) begin
                        clr_cnt_d = '0;
                        state_d   = DRAW;
                    end else begin
                        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = DRAW;
        endcase

        if (wr_acc && !wr_in_range && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge pixel_clk or negedge pixel_clk_rstn) begin
        if (!pixel_clk_rstn) begin
            state_q      <= DRAW;
            front_sel_q  <= 1'b0;
            clr_cnt_q    <= '0;
            drop_count_q <= '0;
            rd_pend_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            front_sel_q  <= front_sel_d;
            clr_cnt_q    <= clr_cnt_d;
            drop_count_q <= drop_count_d;
            // Memory returns one cycle after the request; register it once more.
            rd_pend_q    <= rd_req;
            rd_valid_q   <= rd_pend_q;
            if (rd_pend_q) begin
                rd_data_q <= mem_rdata;
            end
        end
    end

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign front_sel    = front_sel_q;
    assign swap_pending = (state_q == WAIT_SWAP);
    assign clearing     = (state_q == CLEAR);
    assign drop_count   = drop_count_q;

endmodule

// File: tb/tb_fb_arbiter.sv
module tb_fb_arbiter;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 12;
    localparam int unsigned BANKN = 2 ** AW;
    localparam int unsigned MEMN  = 2 ** (AW + 1);
    localparam logic [DW-1:0] CC  = 12'h5A5;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          swap_req = 1'b0;
    logic          vblank_start = 1'b0;
    logic          front_sel;
    logic          swap_pending;
    logic          clearing;
    logic [15:0]   drop_count;
    logic          mem_en;
    logic          mem_we;
    logic [AW:0]   mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    fb_arbiter #(
        .FB_DEPTH     (DEPTH),
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .CLEAR_ON_SWAP(1'b1),
        .CLEAR_COLOR  (CC)
    ) dut (
        .pixel_clk     (clk),
        .pixel_clk_rstn(rstn),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .wr_valid      (wr_valid),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .swap_req      (swap_req),
        .vblank_start  (vblank_start),
        .front_sel     (front_sel),
        .swap_pending  (swap_pending),
        .clearing      (clearing),
        .drop_count    (drop_count),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    // Single-port pixel memory, one-cycle read latency.
    function automatic logic [DW-1:0] pat(input int i);
        return DW'(i * 291 + 7);
    endfunction

    logic          init_mem = 1'b0;
    logic [DW-1:0] mem [0:MEMN-1];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < MEMN; i++) mem[i] <= pat(i);
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural reference: logical framebuffer contents and display mode.
    typedef enum {M_DRAW, M_WAIT, M_CLEAR} mode_t;
    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic [DW-1:0] ref_fb [0:1][0:BANKN-1];
    mode_t         m_mode  = M_DRAW;
    logic          m_front = 1'b0;
    int            m_clr   = 0;
    int            m_drop  = 0;
    exp_t          sb [$];

    // Scoreboard monitor: every rd_valid must match the oldest expected read.
    always @(negedge clk) begin
        exp_t e;
        if (rd_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_valid_unexpected: got rd_valid=1 expected no return (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                chk("rd_data", 32'(rd_data), 32'(e.data));
                chk("rd_latency_cycle", cyc, e.due);
            end
        end
    end

    // One clock of stimulus; the model advances with the same inputs.
    task automatic step(input logic rq, input logic [AW-1:0] ra, input logic wv,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic sw, input logic vb);
        mode_t old;
        bit    inr, acc, exp_en;
        exp_t  e;
        rd_req = rq; rd_addr = ra; wr_valid = wv; wr_addr = wa; wr_data = wd;
        swap_req = sw; vblank_start = vb;
        #2;
        inr    = (int'(wa) < DEPTH);
        acc    = (m_mode == M_DRAW) && wv && !rq;
        exp_en = rq || (m_mode == M_CLEAR) || (acc && inr);
        chk("wr_ready", 32'(wr_ready), 32'((m_mode == M_DRAW) && !rq));
        chk("mem_en", 32'(mem_en), 32'(exp_en));
        if (mem_en && mem_we) chk("write_bank", 32'(mem_addr[AW]), 32'(!m_front));
        if (rq) begin
            chk("read_we", 32'(mem_we), 0);
            e.data = ref_fb[m_front][ra];
            e.due  = cyc + 2;
            sb.push_back(e);
        end
        if (acc) begin
            if (inr) ref_fb[!m_front][wa] = wd;
            else if (m_drop != 16'hFFFF) m_drop++;
        end
        old = m_mode;
        if (old == M_CLEAR && !rq) begin
            ref_fb[!m_front][m_clr] = CC;
            m_clr++;
            if (m_clr == DEPTH) m_mode = M_DRAW;
        end
        if (old == M_DRAW && sw) m_mode = M_WAIT;
        if (((old == M_WAIT) || (old == M_DRAW && sw)) && vb) begin
            m_front = !m_front;
            m_mode  = M_CLEAR;
            m_clr   = 0;
        end
        @(posedge clk);
        #1;
        chk("front_sel", 32'(front_sel), 32'(m_front));
        chk("swap_pending", 32'(swap_pending), 32'(m_mode == M_WAIT));
        chk("clearing", 32'(clearing), 32'(m_mode == M_CLEAR));
        chk("drop_count", 32'(drop_count), m_drop);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rstn = 1'b0; rd_req = 1'b0; wr_valid = 1'b0; swap_req = 1'b0; vblank_start = 1'b0;
        #1;
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_front_sel", 32'(front_sel), 0);
        chk("rst_drop_count", 32'(drop_count), 0);
        chk("rst_status", 32'({swap_pending, clearing}), 0);
        sb.delete();
        m_mode = M_DRAW; m_front = 1'b0; m_clr = 0; m_drop = 0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic mem_compare();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < BANKN; a++)
                chk($sformatf("mem[%0d]", b * BANKN + a), 32'(mem[b * BANKN + a]), 32'(ref_fb[b][a]));
    endtask

    initial begin
        int n;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < BANKN; a++) ref_fb[b][a] = pat(b * BANKN + a);
        init_mem = 1'b1;
        @(posedge clk);
        #1 init_mem = 1'b0;
        do_reset();

        // Write, swap, vblank, then read the pixel back from the new front bank.
        step(1'b0, '0, 1'b1, 5'd5, 12'hABC, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
        chk("front_after_swap", 32'(front_sel), 1);
        step(1'b1, 5'd5, 1'b0, '0, '0, 1'b0, 1'b0);
        n = 0;
        while (clearing && n < 100) begin idle(); n++; end
        chk("clear1_done", 32'(clearing), 0);
        mem_compare();

        // Read/write contention, then the write goes through.
        step(1'b1, 5'd3, 1'b1, 5'd7, 12'h123, 1'b0, 1'b0);
        step(1'b0, 5'd3, 1'b1, 5'd7, 12'h123, 1'b0, 1'b0);
        idle(); idle();

        // Coincident swap+vblank, then clear with rd_req every other cycle.
        step(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b1);
        n = 0;
        while (clearing && n < 200) begin
            step(n % 2 == 0, AW'($urandom_range(0, 31)), 1'b0, '0, '0, 1'b0, 1'b0);
            n++;
        end
        chk("clear_cycles", n, 32);
        idle(); idle();
        mem_compare();

        // Reset in the middle of a clear with a read in flight.
        step(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
        repeat (7) idle();
        step(1'b1, 5'd2, 1'b0, '0, '0, 1'b0, 1'b0);
        do_reset();
        repeat (5) idle();
        mem_compare();

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 4, AW'($urandom_range(0, 31)),
                 $urandom_range(0, 9) < 6, AW'($urandom_range(0, 31)), DW'($urandom),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
        end
        repeat (4) idle();
        mem_compare();

        // Out-of-range writes: boundary, then saturation.
        do_reset();
        step(1'b0, '0, 1'b1, 5'd15, 12'h777, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 5'd16, 12'h888, 1'b0, 1'b0);
        chk("drop_one", 32'(drop_count), 1);
        for (int i = 0; i < 65536; i++) step(1'b0, '0, 1'b1, 5'd31, 12'h999, 1'b0, 1'b0);
        chk("drop_saturated", 32'(drop_count), 32'hFFFF);
        repeat (3) idle();
        mem_compare();
        chk("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 The block SHALL take parameter FB_DEPTH, default 76800, meaning pixels per buffer (320x240).
REQ-002 The block SHALL take parameter ADDR_W, default 17, meaning pixel address width; FB_DEPTH <= 2**ADDR_W.
REQ-003 The block SHALL take parameter DATA_W, default 12, meaning pixel width (RGB444).
REQ-004 The block SHALL take parameter CLEAR_ON_SWAP, default 1, meaning auto-clear the new back buffer after each swap.
REQ-005 The block SHALL take parameter CLEAR_COLOR, default 12'h000, meaning the clear fill value.
REQ-006 The block SHALL have port pixel_clk  in  1  clock; all logic is on its rising edge.
REQ-007 The block SHALL have port pixel_clk_rstn  in  1  reset, asynchronous, active-low.
REQ-008 The block SHALL have port rd_req  in  1  scanout read request.
REQ-009 The block SHALL have port rd_addr  in  ADDR_W  scanout pixel address.
REQ-010 The block SHALL have ports rd_data  out  DATA_W and rd_valid  out  1  scanout return data and its strobe.
REQ-011 The block SHALL have ports wr_valid  in  1, wr_addr  in  ADDR_W and wr_data  in  DATA_W  forming the drawing write request.
REQ-012 The block SHALL have port wr_ready  out  1  write accepted when high together with wr_valid.
REQ-013 The block SHALL have port swap_req  in  1  single-cycle pulse: drawing of back buffer finished.
REQ-014 The block SHALL have port vblank_start  in  1  single-cycle pulse at the first vertical blanking line.
REQ-015 The block SHALL have ports front_sel  out  1 (bank being displayed), swap_pending  out  1 and clearing  out  1 (status).
REQ-016 The block SHALL have port drop_count  out  16  count of out-of-range writes, saturating.
REQ-017 The block SHALL have memory ports mem_en  out  1, mem_we  out  1, mem_addr  out  ADDR_W+1, mem_wdata  out  DATA_W and mem_rdata  in  DATA_W; the memory is single-port with 1-cycle read latency.

Function
REQ-018 The FSM SHALL have states DRAW, WAIT_SWAP and CLEAR.
REQ-019 mem_addr SHALL be {bank, addr}: reads use bank=front_sel, writes and clears use bank=~front_sel.
REQ-020 Read priority: when rd_req=1, the memory port SHALL issue a read (mem_en=1, mem_we=0) that cycle, unconditionally.
REQ-021 rd_data SHALL be registered from mem_rdata; rd_valid SHALL go high exactly 2 cycles after the rd_req cycle, once per request, with back-to-back requests giving back-to-back data.
REQ-022 wr_ready SHALL equal (state==DRAW) && !rd_req, combinationally.
REQ-023 An accepted write SHALL drive mem_en=1, mem_we=1 in the same cycle.
REQ-024 An accepted write with wr_addr >= FB_DEPTH SHALL still be handshaken, SHALL drive mem_en=0 and SHALL increment drop_count, saturating at 16'hFFFF.
REQ-025 DRAW -> WAIT_SWAP SHALL occur on swap_req; swap_req outside DRAW SHALL be ignored.
REQ-026 In WAIT_SWAP, on vblank_start the block SHALL toggle front_sel and go to CLEAR if CLEAR_ON_SWAP=1, else to DRAW.
REQ-027 When swap_req and vblank_start coincide in DRAW, the swap SHALL take effect that same cycle (front_sel toggles on the next edge).
REQ-028 CLEAR SHALL write CLEAR_COLOR to back-buffer addresses 0..FB_DEPTH-1 in ascending order, one per cycle with rd_req=0, stall while rd_req=1 without skipping, and go to DRAW after address FB_DEPTH-1 is written.
REQ-029 swap_pending SHALL be 1 exactly in WAIT_SWAP, and clearing SHALL be 1 exactly in CLEAR.
REQ-030 vblank_start in DRAW or CLEAR SHALL be ignored.
REQ-031 Read/write address mux and FSM SHALL never let a write or clear target bank front_sel.

Reset
REQ-032 While pixel_clk_rstn=0, the block SHALL set state=DRAW, front_sel=0, the clear counter to 0, drop_count=0, rd_valid=0, rd_data=0, mem_en=0, mem_we=0 and wr_ready=0.
REQ-033 Reset mid-CLEAR or mid-WAIT_SWAP SHALL abandon the operation, leave memory contents as written, and not complete the clear.
REQ-034 In-flight read returns SHALL be discarded by reset, so no rd_valid follows deassertion.

Verification
REQ-035 Write then swap: write addr 5 = 12'hABC; swap_req; vblank_start; then rd_req addr 5 -> rd_valid 2 cycles later with rd_data=12'hABC, and front_sel=1.
REQ-036 Contention: rd_req=1 and wr_valid=1 on the same cycle -> wr_ready=0 and a memory read issued; the write completes on the first cycle with rd_req=0.
REQ-037 Out of range: write addr 76800 -> handshake completes, mem_en=0, drop_count=1; 65536 bad writes -> drop_count holds at 16'hFFFF.
REQ-038 Clear: FB_DEPTH=16, swap then rd_req toggling every other cycle -> all 16 back-bank addresses = CLEAR_COLOR, clearing high ~32 cycles, then DRAW.
REQ-039 Coincident events: swap_req and vblank_start in the same cycle in DRAW -> front_sel toggles on the next edge, and swap_pending never visible for more than 0 cycles.
REQ-040 Reset mid-CLEAR at address 7 -> front_sel=0, state DRAW, drop_count=0, no rd_valid after release.
